block_row_scroller: RTL

//  Parametrised falling-block generator for the Blocks game: ROWS x LANES occupancy frame.

---
 rtl/blocks_pkg.sv | 18 +
 rtl/lfsr16.sv | 28 ++
 rtl/block_row_scroller.sv | 98 +++++++++
 3 files changed

// File: rtl/blocks_pkg.sv
// rtl/blocks_pkg.sv - shared constants and helpers for the Blocks game datapath
package blocks_pkg;

  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int SCORE_W = 16;
  localparam int ONEHOT_W = 32;

  // One-hot decode of a lane index; callers cast down to their lane count
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [4:0] idx);
    logic [ONEHOT_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR that advances on request and never holds zero
module lfsr16
  import blocks_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] seed_nz;
  logic              fb;

  // An all-zero seed would lock the register, so substitute 1
  assign seed_nz = (seed == '0) ? 16'h0001 : seed;
  assign fb      = ^(q & LFSR_TAPS);

  // Shift left, feedback into bit 0, only when the caller steps
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed_nz;
    end else if (adv) begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/block_row_scroller.sv
// rtl/block_row_scroller.sv - falling-block frame generator with hit detection and score
module block_row_scroller
  import blocks_pkg::*;
#(
  parameter int          LANES = 4,
  parameter int          ROWS  = 8,
  parameter int          CNT_W = 32,
  parameter logic [15:0] SEED  = 16'hACE1
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CNT_W-1:0]         period,
  input  logic                     hit_valid,
  input  logic [$clog2(LANES)-1:0] hit_lane,
  output logic [ROWS*LANES-1:0]    frame,
  output logic                     step,
  output logic                     miss,
  output logic                     hit_ok,
  output logic [SCORE_W-1:0]       score
);

  localparam int LW  = $clog2(LANES);
  localparam int FW  = ROWS * LANES;
  localparam int BOT = (ROWS - 1) * LANES;

  logic [CNT_W-1:0]  counter;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_unused;
  logic              do_step;
  logic              hit_fire;
  logic [LANES-1:0]  bottom;
  logic [LANES-1:0]  hit_mask;
  logic [LANES-1:0]  bottom_left;
  logic [LANES-1:0]  new_row;
  logic [FW-1:0]     frame_hit;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (do_step),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Only the low lane-select bits of the LFSR pick the new block
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:LW];

  // >= so that shrinking period below the running count steps right away
  assign do_step     = en && (counter >= period);
  assign bottom      = frame[BOT +: LANES];
  assign hit_fire    = en && hit_valid && (int'(hit_lane) < LANES) && bottom[hit_lane];
  assign hit_mask    = hit_fire ? LANES'(onehot(5'(hit_lane))) : '0;
  assign bottom_left = bottom & ~hit_mask;
  assign new_row     = LANES'(onehot(5'(lfsr_q[LW-1:0])));

  // Frame with the player's hit applied to the bottom row, before any shift
  always_comb begin
    frame_hit = frame;
    frame_hit[BOT +: LANES] = bottom_left;
  end

  // Period counter, frame shift, pulses and saturating score
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      frame   <= '0;
      step    <= 1'b0;
      miss    <= 1'b0;
      hit_ok  <= 1'b0;
      score   <= '0;
    end else begin
      step   <= 1'b0;
      miss   <= 1'b0;
      hit_ok <= 1'b0;
      if (en) begin
        if (hit_fire) begin
          hit_ok <= 1'b1;
          if (score != '1) begin
            score <= score + 1'b1;
          end
        end
        if (do_step) begin
          counter <= '0;
          step    <= 1'b1;
          // A block the player cleared this cycle does not count as a miss
          miss    <= |bottom_left;
          frame   <= {frame_hit[BOT-1:0], new_row};
        end else begin
          counter <= counter + 1'b1;
          frame   <= frame_hit;
        end
      end
    end
  end

endmodule
